// File: rtl/keypad_scanner.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_scanner
//  Purpose  : 4x4 matrix keypad scanner with press/release debounce; emits a
//             4-bit key code with a one-cycle valid strobe.
//  Revision : 1.0  initial release
// ============================================================================
module keypad_scanner #(
    parameter int SCAN_DIV = 1000,
    parameter int DEBOUNCE = 20000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int c_cnt_max = (SCAN_DIV > DEBOUNCE) ? SCAN_DIV : DEBOUNCE;
    localparam int c_cnt_w   = $clog2(c_cnt_max);

    localparam logic [c_cnt_w-1:0] c_scan_last = c_cnt_w'(SCAN_DIV - 1);
    localparam logic [c_cnt_w-1:0] c_deb_last  = c_cnt_w'(DEBOUNCE - 1);

    // Nibble {row, col} holds the code; row 3 carries *=F, 0, #=E, D.
    localparam logic [63:0] c_key_map = 64'hDE0F_C987_B654_A321;

    typedef enum logic [1:0] {
        ST_SCAN     = 2'd0,
        ST_DEBOUNCE = 2'd1,
        ST_HOLD     = 2'd2,
        ST_RELEASE  = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state;
    logic [3:0]         r_sync1;
    logic [3:0]         r_col_s;
    logic [c_cnt_w-1:0] r_cnt;
    logic [c_cnt_w-1:0] w_cnt;
    logic [1:0]         r_row;
    logic [1:0]         w_row;
    logic [3:0]         r_pat;
    logic [3:0]         w_pat;
    logic [3:0]         r_row_n;
    logic [3:0]         r_key_code;
    logic [3:0]         w_key_code;
    logic               r_key_valid;
    logic               w_key_valid;
    logic               r_key_held;
    logic               w_key_held;
    logic               w_col_valid;
    logic [1:0]         w_col_idx;

    assign row_n     = r_row_n;
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

    assign w_col_valid = $onehot(~r_col_s);

    always_comb begin
        case (r_pat)
            4'b1110: w_col_idx = 2'd0;
            4'b1101: w_col_idx = 2'd1;
            4'b1011: w_col_idx = 2'd2;
            default: w_col_idx = 2'd3;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SCAN;
            r_sync1     <= 4'b1111;
            r_col_s     <= 4'b1111;
            r_cnt       <= '0;
            r_row       <= 2'd0;
            r_pat       <= 4'b1111;
            r_row_n     <= 4'b1110;
            r_key_code  <= 4'h0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_sync1     <= col_n;
            r_col_s     <= r_sync1;
            r_cnt       <= w_cnt;
            r_row       <= w_row;
            r_pat       <= w_pat;
            r_row_n     <= ~(4'b0001 << w_row);
            r_key_code  <= w_key_code;
            r_key_valid <= w_key_valid;
            r_key_held  <= w_key_held;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_row       = r_row;
        w_pat       = r_pat;
        w_key_code  = r_key_code;
        w_key_valid = 1'b0;
        w_key_held  = r_key_held;
        case (r_state)
            ST_SCAN: begin
                if (r_cnt == c_scan_last) begin
                    w_cnt = '0;
                    if (w_col_valid) begin
                        w_pat   = r_col_s;
                        w_state = ST_DEBOUNCE;
                    end else begin
                        w_row = r_row + 2'd1;
                    end
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_DEBOUNCE: begin
                if (r_col_s != r_pat) begin
                    w_state = ST_SCAN;
                    w_row   = r_row + 2'd1;
                    w_cnt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state     = ST_HOLD;
                    w_key_code  = c_key_map[{r_row, w_col_idx, 2'b00} +: 4];
                    w_key_valid = 1'b1;
                    w_key_held  = 1'b1;
                    w_cnt       = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            ST_HOLD: begin
                w_cnt = '0;
                if (r_col_s == 4'b1111) begin
                    w_state = ST_RELEASE;
                end
            end
            ST_RELEASE: begin
                if (r_col_s != 4'b1111) begin
                    w_state = ST_HOLD;
                    w_cnt   = '0;
                end else if (r_cnt == c_deb_last) begin
                    w_state    = ST_SCAN;
                    w_key_held = 1'b0;
                    w_row      = r_row + 2'd1;
                    w_cnt      = '0;
                end else begin
                    w_cnt = r_cnt + 1'b1;
                end
            end
            default: begin
                w_state = ST_SCAN;
                w_cnt   = '0;
            end
        endcase
    end

endmodule
`default_nettype wire
